// File: rtl/wb_slave_arbiter_pkg.sv
// Shared types and constants for the Wishbone slave-port arbiter:
// bus widths, FSM state encoding and the muxed slave-request bundle.
package wb_slave_arbiter_pkg;

    localparam int DAT_W = 32;
    localparam int ADR_W = 32;
    localparam int SEL_W = 4;

    // Arbiter FSM states; encodings are fixed so they read the same in waveforms.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // One master's request as presented to the slave port.
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    // Width of a master index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_slave_arbiter_rr_pick.sv
// Round-robin picker: grants the first requesting master found when
// searching upward from ptr, wrapping modulo NUM_M. Purely combinational.
module wb_slave_arbiter_rr_pick
    import wb_slave_arbiter_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int PTR_W = ptr_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM_M-1:0] gnt,
    output logic [PTR_W-1:0] idx
);

    logic found;

    // Scan priority slots ptr, ptr+1, ... and take the first active request.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (!found && req[k] && (k == ((int'(ptr) + i) % NUM_M))) begin
                    gnt[k] = 1'b1;
                    idx    = PTR_W'(k);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Shares one Wishbone classic slave port between NUM_M masters.
// Round-robin arbitration, one outstanding transfer, and a watchdog that
// terminates a transfer the slave never acknowledges with an error pulse.
module wb_slave_arbiter
    import wb_slave_arbiter_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic [NUM_M-1:0]       m_cyc_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [SEL_W*NUM_M-1:0] m_sel_i,
    input  logic [ADR_W*NUM_M-1:0] m_adr_i,
    input  logic [DAT_W*NUM_M-1:0] m_dat_i,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [SEL_W-1:0]       s_sel_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    input  logic                   s_ack_i,
    input  logic [DAT_W-1:0]       s_dat_i,
    output logic [NUM_M-1:0]       gnt_o,
    output logic                   tmo_flag_o
);

    localparam int PTR_W = ptr_width(NUM_M);

    state_e           state;
    logic [NUM_M-1:0] gnt;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_flag;

    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    wb_req_t          sel_req;
    logic             busy;
    logic             own_req;
    logic             ack_hit;
    logic             abort;
    logic             tmo_hit;

    // Pointer to the master after the one just served, wrapping at NUM_M.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
        if (cur >= PTR_W'(NUM_M - 1)) begin
            return '0;
        end
        return cur + PTR_W'(1);
    endfunction

    assign req = m_cyc_i & m_stb_i;

    wb_slave_arbiter_rr_pick #(
        .NUM_M (NUM_M),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Select the granted master's bus signals; all zero while nothing is granted.
    always_comb begin
        sel_req = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (gnt[k]) begin
                sel_req.cyc = sel_req.cyc | m_cyc_i[k];
                sel_req.stb = sel_req.stb | m_stb_i[k];
                sel_req.we  = sel_req.we  | m_we_i[k];
                sel_req.sel = sel_req.sel | m_sel_i[k*SEL_W +: SEL_W];
                sel_req.adr = sel_req.adr | m_adr_i[k*ADR_W +: ADR_W];
                sel_req.dat = sel_req.dat | m_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

    // BUSY-cycle outcomes with precedence ack > abort > timeout.
    assign busy    = (state == BUSY);
    assign own_req = |(req & gnt);
    assign ack_hit = busy & s_ack_i;
    assign abort   = busy & ~s_ack_i & ~own_req;
    assign tmo_hit = busy & ~s_ack_i & own_req & (tmo_cnt >= TMO_W'(TIMEOUT));

    // Drive the slave port and master responses; only BUSY ever touches them.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (busy) begin
            // A timed-out transfer withdraws cyc/stb in the same cycle it reports the error.
            s_cyc_o = sel_req.cyc & ~tmo_hit;
            s_stb_o = sel_req.stb & ~tmo_hit;
            s_we_o  = sel_req.we;
            s_sel_o = sel_req.sel;
            s_adr_o = sel_req.adr;
            s_dat_o = sel_req.dat;
        end
        if (ack_hit) begin
            m_ack_o = gnt;
            m_dat_o = s_dat_i;
        end
        if (tmo_hit) begin
            m_err_o = gnt;
        end
    end

    assign gnt_o      = gnt;
    assign tmo_flag_o = tmo_flag;

    // Arbitration FSM: grant in IDLE, watch the transfer in BUSY, rotate priority in RELEASE.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (|req) begin
                        gnt     <= pick_gnt;
                        gnt_idx <= pick_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // The grant is frozen here; only the watchdog advances.
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_hit) begin
                        tmo_flag <= 1'b1;
                    end
                    if (ack_hit || abort || tmo_hit) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // One quiet cycle lets the slave drop its registered ack.
                    rr_ptr  <= next_ptr(gnt_idx);
                    gnt     <= '0;
                    gnt_idx <= '0;
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    gnt     <= '0;
                    gnt_idx <= '0;
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Scoreboard bench for wb_slave_arbiter: directed transfers push their
// expected ack/err response; a negedge monitor pops and compares it.
module tb_wb_slave_arbiter;

    localparam int NM  = 3;
    localparam int TMO = 6;
    localparam int TW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [4*NM-1:0]  m_sel;
    logic [32*NM-1:0] m_adr, m_dat;
    logic [NM-1:0]    m_ack_o, m_err_o, gnt_o;
    logic [31:0]      m_dat_o;
    logic             s_cyc_o, s_stb_o, s_we_o, tmo_flag_o;
    logic [3:0]       s_sel_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic             s_ack;

    // Slave model: registered single-cycle ack after slave_delay extra cycles.
    logic        s_ack_q;
    logic [31:0] s_rdat;
    logic        force_ack;
    logic        slave_never;
    int          slave_delay;
    int          wait_cnt;
    logic [31:0] mem [16];

    assign s_ack = s_ack_q | force_ack;

    wb_slave_arbiter #(.NUM_M(NM), .TIMEOUT(TMO), .TMO_W(TW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_we_i     (m_we),
        .m_sel_i    (m_sel),
        .m_adr_i    (m_adr),
        .m_dat_i    (m_dat),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .m_dat_o    (m_dat_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_sel_o    (s_sel_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_ack_i    (s_ack),
        .s_dat_i    (s_rdat),
        .gnt_o      (gnt_o),
        .tmo_flag_o (tmo_flag_o)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack_q  <= 1'b0;
            s_rdat   <= 32'hDEADBEEF;
            wait_cnt <= 0;
        end else if (s_cyc_o && s_stb_o && !s_ack_q && !slave_never) begin
            if (wait_cnt == slave_delay) begin
                s_ack_q  <= 1'b1;
                wait_cnt <= 0;
                if (s_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                    s_rdat <= 32'h0;
                end else begin
                    s_rdat <= mem[s_adr_o[5:2]];
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            s_ack_q  <= 1'b0;
            s_rdat   <= 32'hDEADBEEF;
            wait_cnt <= 0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [31:0]   dat;
        string         tag;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int k, input logic is_err, input logic [31:0] dat, input string tag);
        exp_t e;
        e.ack = '0;
        e.err = '0;
        if (is_err) e.err[k] = 1'b1;
        else        e.ack[k] = 1'b1;
        e.dat = dat;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: every response is matched in order; read data must be 0 otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|m_ack_o || |m_err_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(m_ack_o | m_err_o), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_ack"}, 32'(m_ack_o), 32'(e.ack));
                    check({e.tag, "_err"}, 32'(m_err_o), 32'(e.err));
                    check({e.tag, "_dat"}, m_dat_o, e.dat);
                    if (|m_err_o) check({e.tag, "_cycstb_on_err"}, {30'h0, s_cyc_o, s_stb_o}, 32'h0);
                end
            end else begin
                check("dat_without_ack", m_dat_o, 32'h0);
            end
        end
    end

    task automatic master_xfer(input int k, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               output int gwait, output int rlat, output logic gstb);
        int b0;
        gwait = -1;
        rlat  = -1;
        gstb  = 1'b0;
        b0    = 0;
        @(posedge clk); #1;
        m_cyc[k] = 1'b1;
        m_stb[k] = 1'b1;
        m_we[k]  = we;
        m_sel[4*k +: 4]   = sel;
        m_adr[32*k +: 32] = adr;
        m_dat[32*k +: 32] = dat;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (gwait < 0 && gnt_o[k]) begin
                gwait = n;
                b0    = n;
                gstb  = s_stb_o;
            end
            if (m_ack_o[k] || m_err_o[k]) begin
                rlat = n - b0;
                break;
            end
        end
        if (rlat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_bound: master %0d got no response in 300 cycles", k);
        end
        @(posedge clk); #1;
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
    endtask

    task automatic wait_gnt(input int k);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (gnt_o[k]) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_bound: master %0d never granted", k);
        end
    endtask

    task automatic wait_resp(input int k);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (m_ack_o[k] || m_err_o[k]) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_bound: master %0d got no response", k);
        end
        @(posedge clk); #1;
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int   g, r, g0, r0, g1, r1;
    logic gs, gs0, gs1;

    initial begin
        #200000;
        $display("FAIL global_watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        force_ack = 1'b0; slave_never = 1'b0; slave_delay = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_s_cyc_stb", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        check("rst_ack_err", 32'(m_ack_o | m_err_o), 32'h0);
        check("rst_m_dat", m_dat_o, 32'h0);
        check("rst_tmo_flag", 32'(tmo_flag_o), 32'h0);
        rst_n = 1'b1;

        // 1: single master write, partial-select write, read-backs.
        push(0, 1'b0, 32'h0, "t1_wr");
        master_xfer(0, 1'b1, 32'h8, 32'h12345678, 4'hF, g, r, gs);
        check("t1_grant_lat", 32'(g), 32'd1);
        check("t1_stb_at_grant", 32'(gs), 32'd1);
        check("t1_ack_lat", 32'(r), 32'd1);
        force_ack = 1'b1;
        #1 check("late_ack_release", 32'(m_ack_o), 32'h0);
        check("late_ack_release_dat", m_dat_o, 32'h0);
        @(posedge clk); #1;
        check("late_ack_idle", 32'(m_ack_o), 32'h0);
        force_ack = 1'b0;
        push(0, 1'b0, 32'h12345678, "t1_rd");
        master_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, g, r, gs);
        push(0, 1'b0, 32'h0, "t1_wr_sel");
        master_xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0011, g, r, gs);
        push(0, 1'b0, 32'h1234CCDD, "t1_rd_sel");
        master_xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, g, r, gs);

        // 2: two masters from reset alternate m0, m1, m0, m1.
        do_reset();
        push(0, 1'b0, 32'h0, "t2_m0_a");
        push(1, 1'b0, 32'h0, "t2_m1_a");
        push(0, 1'b0, 32'h0, "t2_m0_b");
        push(1, 1'b0, 32'h0, "t2_m1_b");
        fork
            begin
                master_xfer(0, 1'b1, 32'h10, 32'h11110000, 4'hF, g0, r0, gs0);
                master_xfer(0, 1'b1, 32'h18, 32'h11112222, 4'hF, g0, r0, gs0);
            end
            begin
                master_xfer(1, 1'b1, 32'h14, 32'h22220000, 4'hF, g1, r1, gs1);
                master_xfer(1, 1'b1, 32'h1C, 32'h22221111, 4'hF, g1, r1, gs1);
            end
        join
        push(2, 1'b0, 32'h11110000, "t2_m2_rd");
        master_xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, g, r, gs);

        // 4: ack lands in the timeout cycle -> plain ack, no error.
        slave_delay = TMO - 1;
        push(1, 1'b0, 32'h0, "t4_ack_at_tmo");
        master_xfer(1, 1'b1, 32'h20, 32'h44444444, 4'hF, g, r, gs);
        check("t4_ack_lat", 32'(r), 32'(TMO));
        check("t4_tmo_flag", 32'(tmo_flag_o), 32'h0);
        slave_delay = 0;

        // 3: slave never acks -> error after TIMEOUT BUSY cycles, sticky flag.
        slave_never = 1'b1;
        push(2, 1'b1, 32'h0, "t3_tmo");
        master_xfer(2, 1'b1, 32'h24, 32'h33333333, 4'hF, g, r, gs);
        check("t3_err_lat", 32'(r), 32'(TMO));
        check("t3_tmo_flag", 32'(tmo_flag_o), 32'h1);
        slave_never = 1'b0;
        push(0, 1'b0, 32'h0, "t3_next");
        master_xfer(0, 1'b1, 32'h28, 32'h55555555, 4'hF, g, r, gs);
        check("t3_next_lat", 32'(r), 32'd1);
        check("t3_flag_sticky", 32'(tmo_flag_o), 32'h1);

        // 5: granted master aborts; pending master is served next.
        slave_never = 1'b1;
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[31:0] = 32'h30; m_sel[3:0] = 4'hF;
        wait_gnt(0);
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_adr[63:32] = 32'h8; m_sel[7:4] = 4'hF;
        repeat (2) @(posedge clk);
        #1 m_stb[0] = 1'b0;
        #1;
        check("t5_abort_stb", 32'(s_stb_o), 32'h0);
        check("t5_abort_cyc", 32'(s_cyc_o), 32'h1);
        check("t5_abort_resp", 32'(m_ack_o | m_err_o), 32'h0);
        @(posedge clk); #1;
        check("t5_release_bus", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        m_cyc[0] = 1'b0;
        slave_never = 1'b0;
        push(1, 1'b0, 32'h1234CCDD, "t5_m1_rd");
        @(posedge clk); #1;
        check("t5_idle_gnt", 32'(gnt_o), 32'h0);
        @(posedge clk); #1;
        check("t5_next_gnt", 32'(gnt_o), 32'h2);
        wait_resp(1);
        check("t5_flag_sticky", 32'(tmo_flag_o), 32'h1);

        // 6: read 0xCAFEF00D, then reset in the middle of a transfer.
        push(1, 1'b0, 32'h0, "t6_wr");
        master_xfer(1, 1'b1, 32'hC, 32'hCAFEF00D, 4'hF, g, r, gs);
        push(2, 1'b0, 32'hCAFEF00D, "t6_rd");
        master_xfer(2, 1'b0, 32'hC, 32'h0, 4'hF, g, r, gs);
        check("t6_rd_lat", 32'(r), 32'd1);
        slave_never = 1'b1;
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[31:0] = 32'h34; m_dat[31:0] = 32'h77777777; m_sel[3:0] = 4'hF;
        wait_gnt(0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt_o), 32'h0);
        check("t6_rst_s_cyc_stb", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        check("t6_rst_s_adr", s_adr_o, 32'h0);
        check("t6_rst_s_dat", s_dat_o, 32'h0);
        check("t6_rst_ack_err", 32'(m_ack_o | m_err_o), 32'h0);
        check("t6_rst_tmo_flag", 32'(tmo_flag_o), 32'h0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        slave_never = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
